// File: rtl/ymux2_arbiter.sv
// Round-robin arbiter feeding a 2:1 yMux2 into a single-entry valid/ready output stage.
// Define YMUX2_ARB_STATS_EN to add the a_count/b_count acceptance counters.

module yMux2 #(
  parameter int SIZE = 2
) (
  output logic [SIZE-1:0] z,
  input  logic [SIZE-1:0] a,
  input  logic [SIZE-1:0] b,
  input  logic            c
);
  genvar gi;
  for (gi = 0; gi < SIZE; gi++) begin : g_bit
    assign z[gi] = c ? b[gi] : a[gi];
  end
endmodule

module ymux2_arbiter #(
  parameter int WIDTH = 2,
  parameter int BURST = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] a_data,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [WIDTH-1:0] b_data,
  input  logic             b_valid,
  output logic             b_ready,
  output logic [WIDTH-1:0] z_data,
  output logic             z_valid,
  input  logic             z_ready,
  output logic             z_sel
`ifdef YMUX2_ARB_STATS_EN
  ,
  output logic [15:0]      a_count,
  output logic [15:0]      b_count
`endif
);
  localparam int            CW      = (BURST > 1) ? $clog2(BURST) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(BURST - 1);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] z_data_q;
  logic             z_sel_q;
  logic             last_q;
  logic [CW-1:0]    burst_cnt_q;
  logic [CW-1:0]    burst_cnt_d;
  logic             open;
  logic             load;
  logic             pick;
  logic [WIDTH-1:0] mux_z;

  always_comb begin
    open = (state_q == EMPTY) || z_ready;
    load = reset_n && open && (a_valid || b_valid);
    if (a_valid && b_valid) begin
      pick = (burst_cnt_q < CNT_MAX) ? last_q : ~last_q;
    end else begin
      pick = b_valid;
    end
    a_ready = load && !pick;
    b_ready = load && pick;
    if (pick == last_q) begin
      burst_cnt_d = (burst_cnt_q == CNT_MAX) ? CNT_MAX : burst_cnt_q + 1'b1;
    end else begin
      burst_cnt_d = '0;
    end
  end

  yMux2 #(.SIZE(WIDTH)) u_mux (
    .z (mux_z),
    .a (a_data),
    .b (b_data),
    .c (pick)
  );

  // Reset looks like B just finished a full burst, so A wins the first contention.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= EMPTY;
      z_data_q    <= '0;
      z_sel_q     <= 1'b0;
      last_q      <= 1'b1;
      burst_cnt_q <= CNT_MAX;
    end else if (load) begin
      state_q     <= FULL;
      z_data_q    <= mux_z;
      z_sel_q     <= pick;
      last_q      <= pick;
      burst_cnt_q <= burst_cnt_d;
    end else if (z_ready) begin
      state_q     <= EMPTY;
    end
  end

  assign z_data  = z_data_q;
  assign z_sel   = z_sel_q;
  assign z_valid = (state_q == FULL);

`ifdef YMUX2_ARB_STATS_EN
  logic [15:0] a_count_q;
  logic [15:0] b_count_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_count_q <= '0;
      b_count_q <= '0;
    end else begin
      if (a_ready && a_valid && (a_count_q != 16'hFFFF)) a_count_q <= a_count_q + 16'd1;
      if (b_ready && b_valid && (b_count_q != 16'hFFFF)) b_count_q <= b_count_q + 16'd1;
    end
  end

  assign a_count = a_count_q;
  assign b_count = b_count_q;
`endif
endmodule
